// File: rtl/mul_arbiter.sv
// Round-robin request arbiter and operand/response sequencer for the shared multiplier.
// Optional macro MUL_ARB_BACK2BACK_EN: accept the next request on the response-consuming edge.
module mul_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    input  logic [NREQ-1:0]       req_signed,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [2*WIDTH-1:0]    resp_r,
    output logic                  resp_negative,
    output logic                  resp_zero
);
    localparam int unsigned    NPAD = 2 ** IDW;
    localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;
    state_e state_q, state_d;

    logic [IDW-1:0]     last_grant_q;
    logic [WIDTH-1:0]   op_x_q, op_y_q;
    logic               op_signed_q;
    logic [IDW-1:0]     op_id_q;

    logic               arb_en, found, accept;
    logic [IDW-1:0]     grant_idx, cand;
    logic [NPAD-1:0]    valid_pad;
    logic [WIDTH-1:0]   sel_x, sel_y;
    logic               sel_signed;
    logic [2*WIDTH-1:0] ext_x, ext_y, product;

    // Search starts one past the last grant and wraps at NREQ, not at 2^IDW.
    always_comb begin
        valid_pad           = '0;
        valid_pad[NREQ-1:0] = req_valid;
        found               = 1'b0;
        grant_idx           = '0;
        cand                = (last_grant_q == LAST) ? '0 : last_grant_q + 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && valid_pad[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
            cand = (cand == LAST) ? '0 : cand + 1'b1;
        end
    end

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_signed = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_x      = req_x[i*WIDTH +: WIDTH];
                sel_y      = req_y[i*WIDTH +: WIDTH];
                sel_signed = req_signed[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (resp_ready) state_d = accept ? StExec : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        arb_en = (state_q == StIdle);
`ifdef MUL_ARB_BACK2BACK_EN
        if (state_q == StResp && resp_ready) arb_en = 1'b1;
`endif
        resp_valid = (state_q == StResp);
        req_ready  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = arb_en && found && (grant_idx == IDW'(i));
        end
    end

    assign accept = |req_ready;

    // Sign-extending to the full product width makes the truncated product exact in both modes.
    assign ext_x   = {{WIDTH{op_signed_q & op_x_q[WIDTH-1]}}, op_x_q};
    assign ext_y   = {{WIDTH{op_signed_q & op_y_q[WIDTH-1]}}, op_y_q};
    assign product = ext_x * ext_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q  <= LAST;
            op_x_q        <= '0;
            op_y_q        <= '0;
            op_signed_q   <= 1'b0;
            op_id_q       <= '0;
            resp_id       <= '0;
            resp_r        <= '0;
            resp_negative <= 1'b0;
            resp_zero     <= 1'b0;
        end else begin
            if (accept) begin
                last_grant_q <= grant_idx;
                op_x_q       <= sel_x;
                op_y_q       <= sel_y;
                op_signed_q  <= sel_signed;
                op_id_q      <= grant_idx;
            end
            if (state_q == StExec) begin
                resp_id       <= op_id_q;
                resp_r        <= product;
                resp_negative <= op_signed_q & product[2*WIDTH-1];
                resp_zero     <= (product == '0);
            end
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: vector table, scoreboard, backpressure and reset sequences.
// Response spacing expectation follows MUL_ARB_BACK2BACK_EN.
module tb_mul_arbiter;
    localparam int WIDTH = 16;
    localparam int NREQ  = 2;
    localparam int IDW   = 2;
`ifdef MUL_ARB_BACK2BACK_EN
    localparam int PERIOD = 2;
`else
    localparam int PERIOD = 3;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ*WIDTH-1:0] req_y;
    logic [NREQ-1:0]       req_signed;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [2*WIDTH-1:0]    resp_r;
    logic                  resp_negative;
    logic                  resp_zero;

    mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_signed    (req_signed),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_r        (resp_r),
        .resp_negative (resp_negative),
        .resp_zero     (resp_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    r;
        logic           neg;
        logic           zero;
    } exp_t;

    typedef struct {
        int          req;
        logic [15:0] x;
        logic [15:0] y;
        logic        sgn;
        logic [31:0] r;
        logic        neg;
        logic        zero;
    } vec_t;

    exp_t sb[$];
    int   grant_log[$];
    int   resp_cycles[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    vec_t vecs[8];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic exp_t model(input int id, input logic [15:0] x, input logic [15:0] y,
                                   input logic s);
        exp_t               e;
        logic signed [31:0] sp;
        logic [31:0]        up;
        sp     = $signed(x) * $signed(y);
        up     = {16'h0, x} * {16'h0, y};
        e.id   = IDW'(id);
        e.r    = s ? sp : up;
        e.neg  = s & e.r[31];
        e.zero = (e.r == 32'h0);
        return e;
    endfunction

    // Inputs change only at posedge+1, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            if (resp_valid && !resp_ready) check("ready_low_in_stall", 64'(req_ready), 64'd0);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back(model(i, req_x[i*WIDTH +: WIDTH], req_y[i*WIDTH +: WIDTH],
                                       req_signed[i]));
                    grant_log.push_back(i);
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_resp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_id", 64'(resp_id), 64'(e.id));
                    check("sb_r", 64'(resp_r), 64'(e.r));
                    check("sb_neg", 64'(resp_negative), 64'(e.neg));
                    check("sb_zero", 64'(resp_zero), 64'(e.zero));
                end
                resp_cycles.push_back(cycle);
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic [15:0] x, input logic [15:0] y,
                           input logic s);
        req_valid[i]               = v;
        req_x[i*WIDTH +: WIDTH]    = x;
        req_y[i*WIDTH +: WIDTH]    = y;
        req_signed[i]              = s;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_resp_id"}, 64'(resp_id), 64'd0);
        check({tag, "_resp_r"}, 64'(resp_r), 64'd0);
        check({tag, "_resp_neg"}, 64'(resp_negative), 64'd0);
        check({tag, "_resp_zero"}, 64'(resp_zero), 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || resp_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 64'(sb.size() == 0 && !resp_valid), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int n = 0;
        @(posedge clk); #1;
        resp_ready = 1'b1;
        set_req(v.req, 1'b1, v.x, v.y, v.sgn);
        @(negedge clk);
        while (!req_ready[v.req] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("vec_accept", 64'(req_ready[v.req]), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        check("vec_exec_not_valid", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
        check("vec_resp_valid", 64'(resp_valid), 64'd1);
        check("vec_r", 64'(resp_r), 64'(v.r));
        check("vec_id", 64'(resp_id), 64'(v.req));
        check("vec_neg", 64'(resp_negative), 64'(v.neg));
        check("vec_zero", 64'(resp_zero), 64'(v.zero));
        @(posedge clk); #1;
        check("vec_resp_consumed", 64'(resp_valid), 64'd0);
    endtask

    task automatic reset_mid(input int stage);
        int n = 0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        set_req(0, 1'b1, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        check("rst_pre_accept", 64'(req_ready[0]), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        if (stage == 1) begin
            @(posedge clk); #1;
            check("rst_in_resp", 64'(resp_valid), 64'd1);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs(stage == 0 ? "rst_exec" : "rst_resp");
        sb.delete();
        @(posedge clk); #1;
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_stale_resp", 64'(resp_valid), 64'd0);
        end
        grant_log.delete();
        @(posedge clk); #1;
        resp_ready = 1'b0;
        set_req(0, 1'b1, 16'h0003, 16'h0005, 1'b0);
        set_req(1, 1'b1, 16'h0007, 16'h0009, 1'b1);
        @(negedge clk);
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_grant_count", 64'(grant_log.size()), 64'd1);
        if (grant_log.size() > 0) check("rst_first_grant", 64'(grant_log[0]), 64'd0);
        @(posedge clk); #1;
        req_valid  = '0;
        resp_ready = 1'b1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b0, 1'b0};
        vecs[1] = '{1, 16'hFFFF, 16'h0003, 1'b1, 32'hFFFFFFFD, 1'b1, 1'b0};
        vecs[2] = '{0, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b0, 1'b0};
        vecs[3] = '{1, 16'h0000, 16'h1234, 1'b0, 32'h00000000, 1'b0, 1'b1};
        vecs[4] = '{0, 16'h0000, 16'h1234, 1'b1, 32'h00000000, 1'b0, 1'b1};
        vecs[5] = '{1, 16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, 1'b1, 1'b0};
        vecs[6] = '{0, 16'h8000, 16'h8000, 1'b0, 32'h40000000, 1'b0, 1'b0};
        vecs[7] = '{1, 16'hFFFF, 16'h0003, 1'b0, 32'h0002FFFD, 1'b0, 1'b0};

        rst_n      = 1'b0;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        req_signed = '0;
        resp_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_reset_outputs("post_reset");

        for (int v = 0; v < 8; v++) run_vec(vecs[v]);
        drain();

        // Both requesters continuously valid, fresh operands every cycle.
        grant_log.delete();
        resp_cycles.delete();
        @(posedge clk); #1;
        resp_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        drain();
        check("rr_enough_grants", 64'(grant_log.size() >= 8), 64'd1);
        for (int k = 1; k < grant_log.size(); k++) begin
            check("rr_order", 64'(grant_log[k]), 64'((grant_log[k-1] + 1) % NREQ));
        end
        for (int k = 1; k < resp_cycles.size(); k++) begin
            check("rr_period", 64'(resp_cycles[k] - resp_cycles[k-1]), 64'(PERIOD));
        end

        // Response backpressure with both requesters pending.
        begin
            int n = 0;
            grant_log.delete();
            @(posedge clk); #1;
            resp_ready = 1'b0;
            set_req(0, 1'b1, 16'h1234, 16'h5678, 1'b0);
            set_req(1, 1'b1, 16'hFEDC, 16'h0042, 1'b1);
            @(negedge clk);
            while (!resp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            repeat (5) begin
                check("bp_valid_held", 64'(resp_valid), 64'd1);
                check("bp_req_ready_low", 64'(req_ready), 64'd0);
                check("bp_r_stable", 64'(resp_r), 64'(sb.size() > 0 ? sb[0].r : 32'hDEADBEEF));
                check("bp_id_stable", 64'(resp_id), 64'(sb.size() > 0 ? sb[0].id : 2'd3));
                @(negedge clk);
            end
            check("bp_single_grant", 64'(grant_log.size()), 64'd1);
            @(posedge clk); #1;
            req_valid  = '0;
            resp_ready = 1'b1;
            drain();
        end

        reset_mid(0);
        reset_mid(1);

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
